// File: rtl/matrix_op_sequencer_if.sv
// Command/storage/ALU signal bundle for matrix_op_sequencer.
// slave  : the sequencer's view (command, storage and ALU signals in, control out).
// master : the view of the surrounding command FSM / storage / ALU.
interface matrix_op_sequencer_if #(
    parameter int NUM_SLOTS = 10
);
    // command side
    logic                 start_op;
    logic [2:0]           op_type;
    logic [3:0]           op_a_id;
    logic [3:0]           op_b_id;
    logic                 cancel;
    // storage side
    logic [NUM_SLOTS-1:0] slot_valid;
    logic [2:0]           a_m;
    logic [2:0]           a_n;
    logic [2:0]           b_m;
    logic [2:0]           b_n;
    logic                 load_operands;
    logic [3:0]           operand_a_id;
    logic [3:0]           operand_b_id;
    logic [2:0]           res_m;
    logic [2:0]           res_n;
    // ALU side
    logic                 alu_done;
    logic                 alu_start;
    logic [2:0]           alu_op;
    // status
    logic                 op_done;
    logic                 busy;
    logic                 error_flag;
    logic [2:0]           err_code;

    modport slave (
        input  start_op, op_type, op_a_id, op_b_id, cancel,
        input  slot_valid, a_m, a_n, b_m, b_n, alu_done,
        output load_operands, operand_a_id, operand_b_id, res_m, res_n,
        output alu_start, alu_op, op_done, busy, error_flag, err_code
    );

    modport master (
        output start_op, op_type, op_a_id, op_b_id, cancel,
        output slot_valid, a_m, a_n, b_m, b_n, alu_done,
        input  load_operands, operand_a_id, operand_b_id, res_m, res_n,
        input  alu_start, alu_op, op_done, busy, error_flag, err_code
    );
endinterface

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: runs one matrix operation at a time between the command
// FSM and the storage/ALU pair: ID/op validation, operand load, dimension check,
// ALU start, completion wait, then result-dimension handoff.
// Optional build macro OP_TIMEOUT_EN: aborts WAIT_ALU with error code 4 after
// TIMEOUT_CYCLES cycles without alu_done. Without it WAIT_ALU waits until
// alu_done or cancel.
module matrix_op_sequencer #(
    parameter int NUM_SLOTS      = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    matrix_op_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT_DIM,
        CHECK,
        EXEC,
        WAIT_ALU,
        DONE,
        ERR
    } state_t;

    localparam logic [2:0] OP_ADD       = 3'd0;
    localparam logic [2:0] OP_SUB       = 3'd1;
    localparam logic [2:0] OP_MUL       = 3'd2;
    localparam logic [2:0] OP_SCALAR    = 3'd3;
    localparam logic [2:0] OP_TRANSPOSE = 3'd4;

    localparam logic [2:0] E_NONE    = 3'd0;
    localparam logic [2:0] E_ID      = 3'd1;
    localparam logic [2:0] E_OP      = 3'd2;
    localparam logic [2:0] E_DIM     = 3'd3;
    localparam logic [2:0] E_TIMEOUT = 3'd4;
    localparam logic [2:0] E_CANCEL  = 3'd5;

    // IDs are 4 bits wide, so compare against the slot count in 5 bits
    localparam logic [4:0] SLOT_LIMIT = 5'(NUM_SLOTS);

    state_t     state_reg;
    state_t     state_next;

    logic [2:0] op_reg;
    logic [3:0] a_id_reg;
    logic [3:0] b_id_reg;
    logic [2:0] res_m_reg;
    logic [2:0] res_n_reg;
    logic [2:0] err_code_reg;

    logic       accept;
    logic [2:0] err_set;
    logic       err_load;
    logic       cancellable;
    logic       timeout_hit;

    logic [15:0] valid_ext;
    logic        a_id_ok;
    logic        b_id_ok;
    logic        b_used;

    logic        dims_ok;
    logic [2:0]  res_m_calc;
    logic [2:0]  res_n_calc;

    logic        load_pulse;
    logic        start_pulse;
    logic        done_pulse;
    logic        err_pulse;
    logic        busy_level;

    // Widen the slot mask to the full 4-bit ID space so any ID indexes safely
    always_comb begin
        valid_ext                  = '0;
        valid_ext[NUM_SLOTS-1:0]   = bus.slot_valid;
    end

    // Operand ID legality on the incoming request (B only matters for two-operand ops)
    always_comb begin
        a_id_ok = ({1'b0, bus.op_a_id} < SLOT_LIMIT) && valid_ext[bus.op_a_id];
        b_id_ok = ({1'b0, bus.op_b_id} < SLOT_LIMIT) && valid_ext[bus.op_b_id];
        b_used  = (bus.op_type == OP_ADD) || (bus.op_type == OP_SUB) ||
                  (bus.op_type == OP_MUL);
    end

    // Dimension rule and result shape for the latched operation
    always_comb begin
        dims_ok    = 1'b0;
        res_m_calc = bus.a_m;
        res_n_calc = bus.a_n;
        case (op_reg)
            OP_ADD, OP_SUB: begin
                dims_ok = (bus.a_m == bus.b_m) && (bus.a_n == bus.b_n);
            end
            OP_MUL: begin
                dims_ok    = (bus.a_n == bus.b_m);
                res_n_calc = bus.b_n;
            end
            OP_SCALAR: begin
                dims_ok = 1'b1;
            end
            OP_TRANSPOSE: begin
                dims_ok    = 1'b1;
                res_m_calc = bus.a_n;
                res_n_calc = bus.a_m;
            end
            default: begin
                dims_ok = 1'b0;
            end
        endcase
    end

    // Cancel applies to every working state; DONE and ERR are already terminal
    always_comb begin
        cancellable = (state_reg == LOAD)  || (state_reg == WAIT_DIM) ||
                      (state_reg == CHECK) || (state_reg == EXEC)     ||
                      (state_reg == WAIT_ALU);
    end

    // Next-state logic; cancel overrides everything else, including alu_done
    always_comb begin
        state_next = state_reg;
        err_set    = E_NONE;
        accept     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.start_op) begin
                    accept = 1'b1;
                    if (bus.op_type > OP_TRANSPOSE) begin
                        state_next = ERR;
                        err_set    = E_OP;
                    end else if (!a_id_ok || (b_used && !b_id_ok)) begin
                        state_next = ERR;
                        err_set    = E_ID;
                    end else begin
                        state_next = LOAD;
                    end
                end
            end
            LOAD:     state_next = WAIT_DIM;
            WAIT_DIM: state_next = CHECK;
            CHECK: begin
                if (dims_ok) begin
                    state_next = EXEC;
                end else begin
                    state_next = ERR;
                    err_set    = E_DIM;
                end
            end
            EXEC:     state_next = WAIT_ALU;
            WAIT_ALU: begin
                if (bus.alu_done) begin
                    state_next = DONE;
                end else if (timeout_hit) begin
                    state_next = ERR;
                    err_set    = E_TIMEOUT;
                end
            end
            DONE:     state_next = IDLE;
            ERR:      state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (cancellable && bus.cancel) begin
            state_next = ERR;
            err_set    = E_CANCEL;
        end
    end

    // The error code is captured on the transition into ERR
    always_comb begin
        err_load = (state_next == ERR);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Latched request, sticky error code and result dims
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg       <= 3'd0;
            a_id_reg     <= 4'd0;
            b_id_reg     <= 4'd0;
            res_m_reg    <= 3'd0;
            res_n_reg    <= 3'd0;
            err_code_reg <= E_NONE;
        end else begin
            if (accept) begin
                op_reg       <= bus.op_type;
                a_id_reg     <= bus.op_a_id;
                b_id_reg     <= bus.op_b_id;
                err_code_reg <= E_NONE;
            end
            if (state_reg == CHECK) begin
                res_m_reg <= res_m_calc;
                res_n_reg <= res_n_calc;
            end
            // a request rejected in IDLE sets its code after the clear above
            if (err_load) begin
                err_code_reg <= err_set;
            end
        end
    end

`ifdef OP_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYCLES) > 10) ? $clog2(TIMEOUT_CYCLES) : 10;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] timeout_cnt_reg;

    // Count WAIT_ALU cycles; restart from zero each time the ALU is kicked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == EXEC) begin
            timeout_cnt_reg <= '0;
        end else if (state_reg == WAIT_ALU) begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg == WAIT_ALU) && (timeout_cnt_reg == TIMEOUT_LAST);
`else
    // No watchdog in this build: WAIT_ALU exits only on alu_done or cancel
    assign timeout_hit = 1'b0;
    wire [31:0] unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
`endif

    // Moore decode of the one-cycle pulses and busy level
    always_comb begin
        load_pulse  = (state_reg == LOAD);
        start_pulse = (state_reg == EXEC);
        done_pulse  = (state_reg == DONE);
        err_pulse   = (state_reg == ERR);
        busy_level  = (state_reg != IDLE);
    end

    assign bus.load_operands = load_pulse;
    assign bus.alu_start     = start_pulse;
    assign bus.op_done       = done_pulse;
    assign bus.error_flag    = err_pulse;
    assign bus.busy          = busy_level;
    assign bus.operand_a_id  = a_id_reg;
    assign bus.operand_b_id  = b_id_reg;
    assign bus.alu_op        = op_reg;
    assign bus.res_m         = res_m_reg;
    assign bus.res_n         = res_n_reg;
    assign bus.err_code      = err_code_reg;

endmodule
